// File: rtl/instr_reg_decode_if.sv
// instr_reg_decode_if: fetch handshake and decoded-instruction bundle between controller and instruction register
interface instr_reg_decode_if;
    logic        fetch_req;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        ir_consume;
    logic        busy;
    logic        ir_valid;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        ext_sign;
    logic        illegal;
    logic        timeout;
    modport slave (
        input  fetch_req, mem_valid, mem_rdata, ir_consume,
        output busy, ir_valid, ir, opcode, rs, rt, rd, shamt, funct, imm16, ext_sign, illegal, timeout
    );
    modport master (
        output fetch_req, mem_valid, mem_rdata, ir_consume,
        input  busy, ir_valid, ir, opcode, rs, rt, rd, shamt, funct, imm16, ext_sign, illegal, timeout
    );
endinterface

// File: rtl/instr_reg_decode.sv
// instr_reg_decode: instruction fetch register with wait timeout and combinational field decode
module instr_reg_decode #(
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    instr_reg_decode_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t      state, state_n;
    logic [31:0] ir_q, ir_n;
    logic        irv_q, irv_n, to_q, to_n;
    logic [7:0]  cnt, cnt_n, cnt_inc;
    logic        legal;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir_q  <= '0;
            irv_q <= 1'b0;
            to_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ir_q  <= ir_n;
            irv_q <= irv_n;
            to_q  <= to_n;
            cnt   <= cnt_n;
        end
    end
    assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    always_comb begin
        state_n = state;
        ir_n    = ir_q;
        irv_n   = irv_q;
        to_n    = to_q;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.fetch_req) begin
                state_n = WAIT;
                cnt_n   = '0;
                to_n    = 1'b0;
            end
            WAIT: if (bus.mem_valid) begin
                state_n = HOLD;
                ir_n    = bus.mem_rdata;
                irv_n   = 1'b1;
            end else begin
                cnt_n = cnt_inc;
                if (cnt_inc == TO) begin
                    state_n = IDLE;
                    to_n    = 1'b1;
                end
            end
            HOLD: if (bus.fetch_req) begin
                state_n = WAIT;
                cnt_n   = '0;
            end else if (bus.ir_consume) begin
                state_n = IDLE;
                irv_n   = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.busy     = (state == WAIT);
    assign bus.ir_valid = irv_q;
    assign bus.ir       = ir_q;
    assign bus.timeout  = to_q;
    assign bus.opcode   = ir_q[31:26];
    assign bus.rs       = ir_q[25:21];
    assign bus.rt       = ir_q[20:16];
    assign bus.rd       = ir_q[15:11];
    assign bus.shamt    = ir_q[10:6];
    assign bus.funct    = ir_q[5:0];
    assign bus.imm16    = ir_q[15:0];
    // logical immediates (andi/ori/xori/lui) zero-extend
    assign bus.ext_sign = (ir_q[31:28] != 4'b0011);
    assign legal = ir_q[31:26] inside {[6'h00:6'h05], [6'h08:6'h10], 6'h1C, 6'h20, 6'h21,
                                       6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    assign bus.illegal  = irv_q && !legal;
endmodule
